// File: rtl/hazard_forward_scoreboard.sv
// rtl/hazard_forward_scoreboard.sv - Scoreboard-based hazard detection and operand forwarding unit
//
// Tracks the destination tags of the STAGES pipeline stages after decode (stage 0 = EX)
// and resolves both decode-stage source operands each cycle. Each source resolves to one of:
// the register file, a forward from the youngest matching stage, or a stall.
//
// Ports:
//   clk, reset        - clock (rising edge), asynchronous active-low reset
//   issue_*           - decode-stage instruction: valid, dst/wr/load, src1/2 and use1/2
//   flush             - branch taken; the decode instruction is killed
//   stage_data        - per-stage result bus, stage i at [i*DATA_W +: DATA_W]
//   stall             - hold PC and decode, insert a bubble into stage 0
//   fwd_sel1/2        - 0 = register file, k = forward from stage k-1
//   fwd_data1/2       - forwarded value, 0 when the select is 0
//   stage_valid       - per-stage valid bits
//   stall_cnt         - saturating count of stall cycles
module hazard_forward_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int REG_W    = 3,
    parameter int STAGES   = 3,
    parameter int ALU_RDY  = 0,
    parameter int LOAD_RDY = 1,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [REG_W-1:0]         issue_dst,
    input  logic                     issue_wr,
    input  logic                     issue_load,
    input  logic [REG_W-1:0]         issue_src1,
    input  logic [REG_W-1:0]         issue_src2,
    input  logic                     issue_use1,
    input  logic                     issue_use2,
    input  logic                     flush,
    input  logic [STAGES*DATA_W-1:0] stage_data,
    output logic                     stall,
    output logic [SEL_W-1:0]         fwd_sel1,
    output logic [SEL_W-1:0]         fwd_sel2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [STAGES-1:0]        stage_valid,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Scoreboard entries, one per tracked stage
    logic [STAGES-1:0] ent_valid;
    logic [STAGES-1:0] ent_wr;
    logic [STAGES-1:0] ent_load;
    logic [REG_W-1:0]  ent_dst [STAGES];

    // Both sources are handled by the same lookup loop
    logic [REG_W-1:0]  src     [2];
    logic [1:0]        use_src;
    logic [SEL_W-1:0]  sel     [2];
    logic [DATA_W-1:0] dat     [2];
    logic [1:0]        found;
    logic [1:0]        hazard;

    assign src[0]     = issue_src1;
    assign src[1]     = issue_src2;
    assign use_src[0] = issue_use1;
    assign use_src[1] = issue_use2;

    // Scan from stage 0 upward; the first match is the youngest writer and
    // masks any older writers of the same register.
    always_comb begin
        found  = '0;
        hazard = '0;
        for (int s = 0; s < 2; s++) begin
            sel[s] = '0;
            dat[s] = '0;
        end
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < STAGES; i++) begin
                if (issue_valid && use_src[s] && !found[s] &&
                    ent_valid[i] && ent_wr[i] && (ent_dst[i] == src[s])) begin
                    found[s] = 1'b1;
                    if (i >= (ent_load[i] ? LOAD_RDY : ALU_RDY)) begin
                        sel[s] = SEL_W'(i + 1);
                        dat[s] = stage_data[i*DATA_W +: DATA_W];
                    end else begin
                        hazard[s] = 1'b1;
                    end
                end
            end
        end
    end

    // Flush takes priority: a killed instruction never stalls
    assign stall       = issue_valid && !flush && (|hazard);
    assign fwd_sel1    = sel[0];
    assign fwd_sel2    = sel[1];
    assign fwd_data1   = dat[0];
    assign fwd_data2   = dat[1];
    assign stage_valid = ent_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid <= '0;
            ent_wr    <= '0;
            ent_load  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                ent_dst[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            // Entry leaving the last stage is simply dropped; the regfile holds it by then
            for (int i = STAGES - 1; i >= 1; i--) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_wr[i]    <= ent_wr[i-1];
                ent_load[i]  <= ent_load[i-1];
                ent_dst[i]   <= ent_dst[i-1];
            end
            // Stall and flush both turn stage 0 into a bubble
            ent_valid[0] <= issue_valid && !stall && !flush;
            ent_wr[0]    <= issue_wr;
            ent_load[0]  <= issue_load;
            ent_dst[0]   <= issue_dst;
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/hazard_forward_scoreboard.md
Name: hazard_forward_scoreboard

Overview:
- Parametrised hazard-detection and forwarding unit for the pipelined core.
- Replaces the fixed two-stage forward unit and single load-use detector with one scoreboard. The scoreboard tracks destination tags for STAGES in-flight pipeline stages after decode.
- Each cycle it resolves both decode-stage source operands: regfile, forward from the youngest matching stage, or stall.
- Bubble insertion, branch flush, and a saturating stall counter are handled internally.

Parameters:
- DATA_W, 16, operand/result width
- REG_W, 3, register-number width
- STAGES, 3, tracked stages after decode (stage 0 = EX, 1 = MEM, 2 = WB)
- ALU_RDY, 0, first stage index at which a non-load result is forwardable
- LOAD_RDY, 1, first stage index at which a load/IN result is forwardable
- CNT_W, 16, stall counter width
- SEL_W, clog2(STAGES+1), forward-select width

Ports:
- clk, in, 1, clock, rising edge
- reset, in, 1, asynchronous, active-low
- issue_valid, in, 1, decode holds a valid instruction
- issue_dst, in, REG_W, destination register number
- issue_wr, in, 1, instruction writes a register
- issue_load, in, 1, result comes from memory/IO (load, POP, IN)
- issue_src1 / issue_src2, in, REG_W, source register numbers
- issue_use1 / issue_use2, in, 1, the source is actually read
- flush, in, 1, branch taken: kill the decode instruction
- stage_data, in, STAGES*DATA_W, result bus per stage; stage i occupies bits [i*DATA_W +: DATA_W]
- stall, out, 1, hold PC and FD/decode, insert bubble
- fwd_sel1 / fwd_sel2, out, SEL_W, 0 = regfile, k = stage k-1
- fwd_data1 / fwd_data2, out, DATA_W, selected forwarded value; 0 when sel = 0
- stage_valid, out, STAGES, per-stage valid bits
- stall_cnt, out, CNT_W, saturating count of stall cycles

Behaviour:
- Scoreboard entry per stage: {valid, wr, load, dst}. Only valid && wr entries participate in matching.
- Reset (reset = 0, asynchronous): all entries cleared and stall_cnt = 0. Resulting outputs: stage_valid = 0, stall = 0, fwd_sel = 0, fwd_data = 0. Reset asserted mid-stall or mid-flush drops all in-flight state immediately.
- Lookup (combinational) for each source with issue_valid && use:
  - find the lowest stage index i whose valid entry has wr and dst == src (youngest writer wins);
  - rdy_i = (i >= (load ? LOAD_RDY : ALU_RDY));
  - match and rdy_i: fwd_sel = i+1, fwd_data = stage_data[i];
  - match and not rdy_i: hazard;
  - no match: fwd_sel = 0.
- A source with use = 0, or issue_valid = 0, always gives fwd_sel = 0 and no hazard.
- stall = issue_valid && !flush && (hazard1 || hazard2).
- When stall = 1, fwd_sel and fwd_data are don't-care but must be driven deterministically by the rule above.
- Clock edge, shift:
  - stage[i] <= stage[i-1] for i >= 1;
  - stage[0] <= {issue_valid && !stall && !flush, issue_wr, issue_load, issue_dst};
  - stall and flush both insert a bubble into stage 0 (valid = 0).
- Simultaneous flush and hazard: flush wins. stall = 0, bubble inserted, stall_cnt not incremented.
- stall_cnt increments by 1 on each edge with stall = 1 and saturates at all-ones (no wrap).
- Load-use latency with defaults: a load followed immediately by a dependent instruction gives exactly (LOAD_RDY − ALU_RDY) = 1 stall cycle.
- A writer leaving the last stage (STAGES−1) is dropped. Later readers get fwd_sel = 0, because the regfile has been written by then.
- Matching compares full REG_W bits. No register is hardwired.

Test Plan:
1. Reset: assert reset = 0 mid-traffic -> stage_valid = 000, stall = 0, stall_cnt = 0, fwd_sel1/2 = 0 immediately, without waiting for a clock edge.
2. ALU back-to-back: issue ADD R1, then next cycle issue_src1 = 1, use1 = 1, stage_data[0] = 16'h1234 -> fwd_sel1 = 1, fwd_data1 = 16'h1234, stall = 0.
3. Load-use: LDD R2, then a reader of R2 -> stall = 1 for one cycle, stage_valid[0] = 0 on the next edge. Then fwd_sel = 2, fwd_data = stage_data[1] = 16'hBEEF, and stall_cnt = 1.
4. Youngest wins: R3 written by the instructions in stage 1 and stage 0, reader of R3 in both src1 and src2 -> fwd_sel1 = fwd_sel2 = 1.
5. Flush with hazard: a load-use hazard pending and flush = 1 -> stall = 0, stage 0 becomes a bubble, stall_cnt unchanged.
6. Saturation: CNT_W = 2, five stall cycles -> stall_cnt = 3. Aged out: a writer reaches stage 3 with STAGES = 3 -> its reader gets fwd_sel = 0.
